// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Tomasulo reservation station in front of the ALU functional unit.
//   Buffers dispatched ALU ops, snoops the CDB for missing operands, issues one
//   ready op at a time to the FU, and tracks it until fu_finish to drive wb_*.
//
//   Build option: RS_AGE_ORDER_EN
//     defined   -> an age matrix is kept and the oldest ready entry issues
//     undefined -> the lowest-index ready entry issues, no age storage
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   disp_valid/disp_ready    dispatch handshake (ready = an entry is free)
//   disp_op/dst/qj/vj/qk/vk  dispatched op, destination tag, operand tags/values
//   cdb_valid/tag/data       common data bus broadcast
//   fu_en, fu_op/a/b         1-cycle issue pulse plus op/operands (held between issues)
//   fu_finish                FU completion, one cycle after fu_en
//   wb_valid, wb_tag         FU result valid this cycle, tag of the in-flight op
//   occupancy                number of valid entries
module alu_reservation_station #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [3:0]       disp_op,
  input  logic [TAG_W-1:0] disp_dst,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [31:0]      disp_vj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [31:0]      disp_vk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             fu_en,
  output logic [3:0]       fu_op,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  input  logic             fu_finish,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [3:0]       occupancy
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned VAL_W = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [OP_W-1:0]    op_q  [DEPTH];
  logic [OP_W-1:0]    op_d  [DEPTH];
  logic [TAG_W-1:0]   dst_q [DEPTH];
  logic [TAG_W-1:0]   dst_d [DEPTH];
  logic [TAG_W-1:0]   qj_q  [DEPTH];
  logic [TAG_W-1:0]   qj_d  [DEPTH];
  logic [TAG_W-1:0]   qk_q  [DEPTH];
  logic [TAG_W-1:0]   qk_d  [DEPTH];
  logic [VAL_W-1:0]   vj_q  [DEPTH];
  logic [VAL_W-1:0]   vj_d  [DEPTH];
  logic [VAL_W-1:0]   vk_q  [DEPTH];
  logic [VAL_W-1:0]   vk_d  [DEPTH];
  logic [OP_W-1:0]    fu_op_q, fu_op_d;
  logic [VAL_W-1:0]   fu_a_q, fu_a_d;
  logic [VAL_W-1:0]   fu_b_q, fu_b_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [DEPTH-1:0]   age_q [DEPTH];
  logic [DEPTH-1:0]   age_d [DEPTH];
`endif

  logic [DEPTH-1:0]   ready;
  logic [DEPTH-1:0]   cand;
  logic [DEPTH-1:0]   sel_oh;
  logic [DEPTH-1:0]   free_oh;
  logic               sel_found;
  logic               free_found;
  logic [CNT_W-1:0]   occ_c;
  logic               disp_fire;

  // Ready / candidate / free-slot selection from registered state only
  always_comb begin
    ready      = '0;
    cand       = '0;
    sel_oh     = '0;
    free_oh    = '0;
    sel_found  = 1'b0;
    free_found = 1'b0;
    occ_c      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      occ_c    = occ_c + CNT_W'(valid_q[i]);
    end
`ifdef RS_AGE_ORDER_EN
    // a ready entry is a candidate only if no other ready entry is older
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cand[i] = ready[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready[j] && age_q[j][i]) cand[i] = 1'b0;
      end
    end
`else
    cand = ready;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && cand[i]) begin
        sel_oh[i] = 1'b1;
        sel_found = 1'b1;
      end
      if (!free_found && !valid_q[i]) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign occupancy  = occ_c;
  assign disp_ready = free_found;
  assign disp_fire  = disp_valid && free_found;
  assign wb_valid   = fu_finish && (state_q == S_BUSY);
  assign wb_tag     = wb_tag_q;

  // Next-state: snoop, issue FSM, dispatch
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    op_d     = op_q;
    dst_d    = dst_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    fu_op_d  = fu_op_q;
    fu_a_d   = fu_a_q;
    fu_b_d   = fu_b_q;
    wb_tag_d = wb_tag_q;
    fu_en    = 1'b0;
`ifdef RS_AGE_ORDER_EN
    age_d    = age_q;
`endif

    // CDB snoop on waiting operands
    if (cdb_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
          vj_d[i] = cdb_data;
          qj_d[i] = '0;
        end
        if (valid_q[i] && (qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
          vk_d[i] = cdb_data;
          qk_d[i] = '0;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          fu_en   = 1'b1;
          state_d = S_BUSY;
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
              fu_op_d    = op_q[i];
              fu_a_d     = vj_q[i];
              fu_b_d     = vk_q[i];
              wb_tag_d   = dst_q[i];
              valid_d[i] = 1'b0;
            end
          end
        end
      end
      S_BUSY: begin
        if (fu_finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dispatch into the lowest free entry, with same-cycle CDB bypass
    if (disp_fire) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (free_oh[i]) begin
          valid_d[i] = 1'b1;
          op_d[i]    = disp_op;
          dst_d[i]   = disp_dst;
          qj_d[i]    = disp_qj;
          vj_d[i]    = disp_vj;
          qk_d[i]    = disp_qk;
          vk_d[i]    = disp_vk;
          if (cdb_valid && (disp_qj != '0) && (disp_qj == cdb_tag)) begin
            qj_d[i] = '0;
            vj_d[i] = cdb_data;
          end
          if (cdb_valid && (disp_qk != '0) && (disp_qk == cdb_tag)) begin
            qk_d[i] = '0;
            vk_d[i] = cdb_data;
          end
`ifdef RS_AGE_ORDER_EN
          // new entry is younger than every currently valid entry
          age_d[i] = '0;
          for (int unsigned j = 0; j < DEPTH; j++) begin
            if (j != i) age_d[j][i] = valid_q[j];
          end
`endif
        end
      end
    end
  end

  // FU outputs show the selected entry during the issue cycle, then hold
  assign fu_op = fu_op_d;
  assign fu_a  = fu_a_d;
  assign fu_b  = fu_b_d;

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      fu_op_q  <= '0;
      fu_a_q   <= '0;
      fu_b_q   <= '0;
      wb_tag_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        dst_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
`ifdef RS_AGE_ORDER_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      fu_op_q  <= fu_op_d;
      fu_a_q   <= fu_a_d;
      fu_b_q   <= fu_b_d;
      wb_tag_q <= wb_tag_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
`ifdef RS_AGE_ORDER_EN
      age_q    <= age_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station (DEPTH=3, TAG_W=3).
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_op;
  logic [2:0]  disp_dst, disp_qj, disp_qk;
  logic [31:0] disp_vj, disp_vk;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        fu_en;
  logic [3:0]  fu_op;
  logic [31:0] fu_a, fu_b;
  logic        fu_finish;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [3:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_reservation_station #(.DEPTH(3), .TAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_dst(disp_dst), .disp_qj(disp_qj), .disp_vj(disp_vj),
    .disp_qk(disp_qk), .disp_vk(disp_vk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_en(fu_en), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_finish(fu_finish), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle and clear single-cycle pulses
  task automatic next();
    @(posedge clk);
    #1;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    fu_finish  = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [2:0] dst,
                      input logic [2:0] qj, input logic [31:0] vj,
                      input logic [2:0] qk, input logic [31:0] vk);
    disp_valid = 1'b1;
    disp_op = op; disp_dst = dst;
    disp_qj = qj; disp_vj = vj;
    disp_qk = qk; disp_vk = vk;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  logic [3:0] first_op, second_op;
  logic [2:0] first_tag, second_tag;

  initial begin
`ifdef RS_AGE_ORDER_EN
    first_op = 4'h9; first_tag = 3'd5; second_op = 4'hA; second_tag = 3'd6;
`else
    first_op = 4'hA; first_tag = 3'd6; second_op = 4'h9; second_tag = 3'd5;
`endif
    rst = 1'b1; disp_valid = 1'b0; cdb_valid = 1'b0; fu_finish = 1'b0;
    disp_op = '0; disp_dst = '0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; cdb_tag = '0; cdb_data = '0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Reset state; stale fu_finish while IDLE is ignored
    next(); fu_finish = 1'b1; #1;
    chk("rst_fu_en", 32'(fu_en), 0);
    chk("rst_fu_op", 32'(fu_op), 0);
    chk("rst_fu_a", fu_a, 0);
    chk("rst_fu_b", fu_b, 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_tag", 32'(wb_tag), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);

    // 1: both operands ready
    next(); disp(4'h1, 3'd2, 3'd0, 32'd5, 3'd0, 32'd7); #1;
    chk("t1_no_en_disp_cycle", 32'(fu_en), 0);
    next(); #1;
    chk("t1_en", 32'(fu_en), 1);
    chk("t1_op", 32'(fu_op), 1);
    chk("t1_a", fu_a, 5);
    chk("t1_b", fu_b, 7);
    chk("t1_occ_issue", 32'(occupancy), 1);
    next(); fu_finish = 1'b1; #1;
    chk("t1_wb_valid", 32'(wb_valid), 1);
    chk("t1_wb_tag", 32'(wb_tag), 2);
    chk("t1_en_busy", 32'(fu_en), 0);
    chk("t1_occ_after", 32'(occupancy), 0);
    chk("t1_a_hold", fu_a, 5);
    next(); #1;
    chk("t1_wb_idle", 32'(wb_valid), 0);

    // 2: pending operand woken by CDB
    next(); disp(4'h2, 3'd3, 3'd4, 32'd0, 3'd0, 32'd3); #1;
    next(); cdb(3'd4, 32'd10); #1;
    chk("t2_wait_en", 32'(fu_en), 0);
    chk("t2_wait_occ", 32'(occupancy), 1);
    next(); #1;
    chk("t2_en", 32'(fu_en), 1);
    chk("t2_op", 32'(fu_op), 2);
    chk("t2_a", fu_a, 10);
    chk("t2_b", fu_b, 3);
    next(); fu_finish = 1'b1; #1;
    chk("t2_wb_tag", 32'(wb_tag), 3);

    // 3: same-cycle bypass on operand B
    next(); disp(4'h3, 3'd1, 3'd0, 32'h1234_5678, 3'd5, 32'd0); cdb(3'd5, 32'hFFFF_FFFF); #1;
    next(); #1;
    chk("t3_en", 32'(fu_en), 1);
    chk("t3_a", fu_a, 32'h1234_5678);
    chk("t3_b", fu_b, 32'hFFFF_FFFF);
    next(); fu_finish = 1'b1; #1;
    chk("t3_wb_valid", 32'(wb_valid), 1);
    chk("t3_wb_tag", 32'(wb_tag), 1);

    // 4: fill, ignored 4th dispatch, sequential issue
    next(); disp(4'h4, 3'd2, 3'd6, 32'd0, 3'd0, 32'd40); #1;
    next(); disp(4'h5, 3'd3, 3'd6, 32'd0, 3'd0, 32'd50); #1;
    next(); disp(4'h6, 3'd4, 3'd6, 32'd0, 3'd0, 32'd60); #1;
    next(); disp(4'h7, 3'd5, 3'd0, 32'd1, 3'd0, 32'd1); cdb(3'd6, 32'h100); #1;
    chk("t4_full_occ", 32'(occupancy), 3);
    chk("t4_full_ready", 32'(disp_ready), 0);
    chk("t4_no_en", 32'(fu_en), 0);
    next(); #1;
    chk("t4_occ_ignored", 32'(occupancy), 3);
    chk("t4_en1", 32'(fu_en), 1);
    chk("t4_op1", 32'(fu_op), 4);
    chk("t4_a1", fu_a, 32'h100);
    chk("t4_b1", fu_b, 40);
    chk("t4_ready_issue_cycle", 32'(disp_ready), 0);
    next(); fu_finish = 1'b1; #1;
    chk("t4_wb1", 32'(wb_tag), 2);
    chk("t4_gap_en", 32'(fu_en), 0);
    chk("t4_occ2", 32'(occupancy), 2);
    chk("t4_ready_after", 32'(disp_ready), 1);
    next(); #1;
    chk("t4_en2", 32'(fu_en), 1);
    chk("t4_op2", 32'(fu_op), 5);
    next(); fu_finish = 1'b1; #1;
    chk("t4_wb2", 32'(wb_tag), 3);
    next(); #1;
    chk("t4_op3", 32'(fu_op), 6);
    chk("t4_en3", 32'(fu_en), 1);
    next(); fu_finish = 1'b1; #1;
    chk("t4_wb3", 32'(wb_tag), 4);
    chk("t4_occ_empty", 32'(occupancy), 0);

    // 5: ordering -- A lands in entry 1, B in entry 0
    next(); disp(4'h8, 3'd1, 3'd0, 32'd1, 3'd0, 32'd1); #1;
    next(); disp(4'h9, 3'd5, 3'd7, 32'd0, 3'd0, 32'hA); #1;
    chk("t5_x_en", 32'(fu_en), 1);
    chk("t5_x_op", 32'(fu_op), 8);
    next(); disp(4'hA, 3'd6, 3'd7, 32'd0, 3'd0, 32'hB); fu_finish = 1'b1; #1;
    chk("t5_x_wb", 32'(wb_tag), 1);
    chk("t5_occ_disp_issue", 32'(occupancy), 1);
    next(); cdb(3'd7, 32'h77); #1;
    chk("t5_occ2", 32'(occupancy), 2);
    chk("t5_wait_en", 32'(fu_en), 0);
    next(); #1;
    chk("t5_first_en", 32'(fu_en), 1);
    chk("t5_first_op", 32'(fu_op), 32'(first_op));
    chk("t5_first_a", fu_a, 32'h77);
    next(); fu_finish = 1'b1; #1;
    chk("t5_first_wb", 32'(wb_tag), 32'(first_tag));
    next(); #1;
    chk("t5_second_op", 32'(fu_op), 32'(second_op));
    next(); fu_finish = 1'b1; #1;
    chk("t5_second_wb", 32'(wb_tag), 32'(second_tag));

    // 6: reset while BUSY discards the in-flight op
    next(); disp(4'hF, 3'd3, 3'd0, 32'd9, 3'd0, 32'd9); #1;
    next(); #1;
    chk("t6_en", 32'(fu_en), 1);
    next(); rst = 1'b1; #1;
    next(); fu_finish = 1'b1; #1;
    chk("t6_wb_valid", 32'(wb_valid), 0);
    chk("t6_occ", 32'(occupancy), 0);
    chk("t6_en_after", 32'(fu_en), 0);
    chk("t6_disp_ready", 32'(disp_ready), 1);
    chk("t6_wb_tag", 32'(wb_tag), 0);
    chk("t6_fu_a", fu_a, 0);

    next(); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
